// File: rtl/weight_tile_fifo.sv
// Tile-granular row FIFO between a weight producer and a systolic-array weight loader.
// Define WFIFO_ERR_FLAGS_EN to add the sticky err_o flags (dropped write, read underflow).
module weight_tile_fifo #(
  parameter int LANES       = 32,
  parameter int DATA_W      = 8,
  parameter int TILE_ROWS   = 32,
  parameter int DEPTH_TILES = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              write_en_i,
  input  logic                              sending_data_i,
  input  logic [LANES*DATA_W-1:0]           data_i,
  input  logic                              read_en_i,
  output logic                              request_data_o,
  output logic                              valid_o,
  output logic [LANES*DATA_W-1:0]           data_o,
  output logic [$clog2(DEPTH_TILES+1)-1:0]  tile_count_o,
  output logic                              tile_done_o
`ifdef WFIFO_ERR_FLAGS_EN
  ,
  output logic [1:0]                        err_o
`endif
);

  // state   | meaning
  // IDLE    | no slot reserved; waits for a free tile slot
  // REQUEST | slot reserved, request_data_o high, waiting for the first row
  // RECEIVE | rows of the reserved tile arriving until TILE_ROWS accepted
  typedef enum logic [1:0] {IDLE, REQUEST, RECEIVE} state_t;

  localparam int W     = LANES * DATA_W;
  localparam int SLOTS = DEPTH_TILES * TILE_ROWS;
  localparam int PW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int RW    = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
  localparam int CW    = $clog2(DEPTH_TILES + 1);

  state_t          r_state;
  logic            r_request;
  logic [W-1:0]    r_mem [SLOTS];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [RW-1:0]   r_wr_row;
  logic [RW-1:0]   r_rd_row;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_data;
  logic            r_done;

  logic            w_filling;
  logic            w_wr_accept;
  logic            w_wr_last;
  logic            w_valid;
  logic            w_rd_accept;
  logic            w_rd_last;
  logic [CW-1:0]   w_free;

  assign w_filling   = (r_state != IDLE);
  assign w_wr_accept = write_en_i && sending_data_i && w_filling;
  assign w_wr_last   = w_wr_accept && (r_wr_row == RW'(TILE_ROWS - 1));
  assign w_valid     = (r_count != '0);
  assign w_rd_accept = read_en_i && w_valid;
  assign w_rd_last   = w_rd_accept && (r_rd_row == RW'(TILE_ROWS - 1));
  // A tile being filled already owns its slot, so it is not free for another request.
  assign w_free      = CW'(DEPTH_TILES) - r_count - CW'(w_filling);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_request <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_free != '0) begin
            r_state   <= REQUEST;
            r_request <= 1'b1;
          end
        end
        REQUEST: begin
          if (w_wr_accept) begin
            r_request <= 1'b0;
            r_state   <= w_wr_last ? IDLE : RECEIVE;
          end
        end
        RECEIVE: begin
          if (w_wr_last) r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_request <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_accept) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_wr_row <= '0;
    end else if (w_wr_accept) begin
      r_wr_ptr <= (r_wr_ptr == PW'(SLOTS - 1)) ? '0 : r_wr_ptr + PW'(1);
      r_wr_row <= w_wr_last ? '0 : r_wr_row + RW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_rd_row <= '0;
      r_data   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_rd_last;
      if (w_rd_accept) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= (r_rd_ptr == PW'(SLOTS - 1)) ? '0 : r_rd_ptr + PW'(1);
        r_rd_row <= w_rd_last ? '0 : r_rd_row + RW'(1);
      end
    end
  end

  // Completion and consumption in the same cycle cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_count <= '0;
    else       r_count <= r_count + CW'(w_wr_last) - CW'(w_rd_last);
  end

`ifdef WFIFO_ERR_FLAGS_EN
  logic [1:0] r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 2'b00;
    end else begin
      if (write_en_i && !w_filling) r_err[0] <= 1'b1;
      if (read_en_i && !w_valid)    r_err[1] <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

  assign request_data_o = r_request;
  assign valid_o        = w_valid;
  assign data_o         = r_data;
  assign tile_count_o   = r_count;
  assign tile_done_o    = r_done;

endmodule

// File: tb/tb_weight_tile_fifo.sv
// Directed bench for weight_tile_fifo at default parameters: per-cycle vector table
// plus a hand-written mid-fill reset sequence.
module tb_weight_tile_fifo;

  localparam int W = 256;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           write_en_i;
  logic           sending_data_i;
  logic [W-1:0]   data_i;
  logic           read_en_i;
  logic           request_data_o;
  logic           valid_o;
  logic [W-1:0]   data_o;
  logic [1:0]     tile_count_o;
  logic           tile_done_o;
  logic [1:0]     err_o;

  weight_tile_fifo dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .write_en_i     (write_en_i),
    .sending_data_i (sending_data_i),
    .data_i         (data_i),
    .read_en_i      (read_en_i),
    .request_data_o (request_data_o),
    .valid_o        (valid_o),
    .data_o         (data_o),
    .tile_count_o   (tile_count_o),
    .tile_done_o    (tile_done_o)
`ifdef WFIFO_ERR_FLAGS_EN
    ,
    .err_o          (err_o)
`endif
  );

`ifndef WFIFO_ERR_FLAGS_EN
  assign err_o = 2'b00;
`endif

  always #5 clk_i = ~clk_i;

  typedef struct {
    string        nm;
    bit           wr;
    bit           rd;
    logic [W-1:0] din;
    logic [W-1:0] e_data;
    bit           e_req;
    bit           e_valid;
    logic [1:0]   e_cnt;
    bit           e_done;
    logic [1:0]   e_err;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [W-1:0] row_word(input int t, input int r);
    logic [W-1:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'((t * 32 + r) ^ (i * 13));
    return v;
  endfunction

  task automatic add(input string nm, input bit wr, input bit rd, input logic [W-1:0] din,
                     input logic [W-1:0] ed, input bit er, input bit ev, input logic [1:0] ec,
                     input bit edn, input logic [1:0] ee);
    vec_t v;
    v.nm = nm; v.wr = wr; v.rd = rd; v.din = din; v.e_data = ed;
    v.e_req = er; v.e_valid = ev; v.e_cnt = ec; v.e_done = edn; v.e_err = ee;
    vq.push_back(v);
  endtask

  task automatic step(input bit wr, input bit snd, input bit rd, input logic [W-1:0] din);
    write_en_i     = wr;
    sending_data_i = snd;
    read_en_i      = rd;
    data_i         = din;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string nm, input logic [W-1:0] ed, input bit er, input bit ev,
                       input logic [1:0] ec, input bit edn, input logic [1:0] ee);
    bit ok;
    ok = (data_o === ed) && (request_data_o === er) && (valid_o === ev) &&
         (tile_count_o === ec) && (tile_done_o === edn);
`ifdef WFIFO_ERR_FLAGS_EN
    ok = ok && (err_o === ee);
`endif
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s got req=%b valid=%b cnt=%0d done=%b err=%b data=%h need req=%b valid=%b cnt=%0d done=%b err=%b data=%h",
                  nm, request_data_o, valid_o, tile_count_o, tile_done_o, err_o, data_o,
                  er, ev, ec, edn, ee, ed);
  endtask

  initial begin
    logic [W-1:0] hold;
    logic [1:0]   ee;

    // Phase A: first tile fill, with an underflow read before anything is resident.
    hold = '0; ee = 2'b00;
    add("a_idle", 0, 0, '0, hold, 1, 0, 2'd0, 0, ee);
    ee = 2'b10;
    add("a_under", 0, 1, '0, hold, 1, 0, 2'd0, 0, ee);
    for (int r = 0; r < 32; r++)
      add("a_fill", 1, 0, row_word(0, r), hold, 0, r == 31, (r == 31) ? 2'd1 : 2'd0, 0, ee);
    // Phase B: back-to-back reads of tile 0, then an ignored read.
    for (int k = 0; k < 32; k++)
      add("b_read", 0, 1, '0, row_word(0, k), 1, k < 31, (k < 31) ? 2'd1 : 2'd0, k == 31, ee);
    hold = row_word(0, 31);
    add("b_under", 0, 1, '0, hold, 1, 0, 2'd0, 0, ee);
    // Phase C: fill to full (tile 2 wraps the write pointer), then a dropped row.
    for (int r = 0; r < 32; r++)
      add("c_fill1", 1, 0, row_word(1, r), hold, 0, r == 31, (r == 31) ? 2'd1 : 2'd0, 0, ee);
    add("c_gap", 0, 0, '0, hold, 1, 1, 2'd1, 0, ee);
    for (int r = 0; r < 32; r++)
      add("c_fill2", 1, 0, row_word(2, r), hold, 0, 1, (r == 31) ? 2'd2 : 2'd1, 0, ee);
    add("c_full", 0, 0, '0, hold, 0, 1, 2'd2, 0, ee);
    ee = 2'b11;
    add("c_drop", 1, 0, row_word(9, 0), hold, 0, 1, 2'd2, 0, ee);
    // Phase D: drain tile 1, then fill tile 3 while reading tile 2, finishing together.
    for (int k = 0; k < 32; k++)
      add("d_read1", 0, 1, '0, row_word(1, k), 0, 1, (k == 31) ? 2'd1 : 2'd2, k == 31, ee);
    hold = row_word(1, 31);
    add("d_gap", 0, 0, '0, hold, 1, 1, 2'd1, 0, ee);
    for (int k = 0; k < 32; k++)
      add("d_ovl", 1, 1, row_word(3, k), row_word(2, k), 0, 1, 2'd1, k == 31, ee);
    // Phase E: tile 3 reads back intact across the read-pointer wrap.
    for (int k = 0; k < 32; k++)
      add("e_read3", 0, 1, '0, row_word(3, k), 1, k < 31, (k < 31) ? 2'd1 : 2'd0, k == 31, ee);

    rst_i = 1'b1; write_en_i = 0; sending_data_i = 0; read_en_i = 0; data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_hold", '0, 0, 0, 2'd0, 0, 2'b00);
    rst_i = 1'b0;
    check("rst_rel", '0, 0, 0, 2'd0, 0, 2'b00);

    foreach (vq[i]) begin
      step(vq[i].wr, vq[i].wr, vq[i].rd, vq[i].din);
      check($sformatf("%s[%0d]", vq[i].nm, i), vq[i].e_data, vq[i].e_req, vq[i].e_valid,
            vq[i].e_cnt, vq[i].e_done, vq[i].e_err);
    end

    // Phase F: reset in the middle of a fill, then a clean tile round trip.
    for (int r = 0; r < 10; r++) step(1, 1, 0, row_word(4, r));
    check("f_partial", row_word(3, 31), 0, 0, 2'd0, 0, 2'b11);
    step(0, 0, 0, '0);
    rst_i = 1'b1;
    #2;
    check("f_rst_async", '0, 0, 0, 2'd0, 0, 2'b00);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("f_rel", '0, 0, 0, 2'd0, 0, 2'b00);
    step(0, 0, 0, '0);
    check("f_req", '0, 1, 0, 2'd0, 0, 2'b00);
    for (int r = 0; r < 31; r++) step(1, 1, 0, row_word(5, r));
    check("f_fill_part", '0, 0, 0, 2'd0, 0, 2'b00);
    step(1, 1, 0, row_word(5, 31));
    check("f_fill_done", '0, 0, 1, 2'd1, 0, 2'b00);
    for (int k = 0; k < 32; k++) begin
      step(0, 0, 1, '0);
      check($sformatf("f_read5[%0d]", k), row_word(5, k), 1, k < 31,
            (k < 31) ? 2'd1 : 2'd0, k == 31, 2'b00);
    end
    step(0, 0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/weight_tile_fifo.md
WEIGHT_TILE_FIFO -- requirements
Module: weight_tile_fifo

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- LANES, 32, lanes per row (systolic array width).
- DATA_W, 8, bits per lane.
- TILE_ROWS, 32, rows per weight tile.
- DEPTH_TILES, 2, tile slots stored (2 or more; not required to be a power of two).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; ports follow (one per line: name, direction, width, meaning).
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- write_en_i  in  1  row write strobe.
- sending_data_i  in  1  producer asserts while delivering requested tile rows.
- data_i  in  LANES x DATA_W  write row.
- read_en_i  in  1  row read request from the weight loader.
- request_data_o  out  1  requests one tile from the producer.
- valid_o  out  1  at least one complete tile resident.
- data_o  out  LANES x DATA_W  registered read row.
- tile_count_o  out  clog2(DEPTH_TILES+1)  complete tiles resident.
- tile_done_o  out  1  one-cycle pulse when the last row of a tile is read.
- err_o  out  2  sticky error flags; present only with WFIFO_ERR_FLAGS_EN.

Function
REQ-003 Storage SHALL be DEPTH_TILES*TILE_ROWS rows; write and read pointers SHALL wrap explicitly from DEPTH_TILES*TILE_ROWS-1 to 0.
REQ-004 The fill FSM SHALL have states IDLE, REQUEST and RECEIVE.
- IDLE->REQUEST when free slots >= 1.
- REQUEST->RECEIVE on the first accepted row.
- RECEIVE->IDLE in the cycle the TILE_ROWS-th row of the tile is accepted.
REQ-005 request_data_o SHALL equal (state==REQUEST), registered.
REQ-006 A row SHALL be accepted iff write_en_i && sending_data_i && state is REQUEST or RECEIVE.
REQ-007 Rows offered outside REQUEST or RECEIVE SHALL be dropped and SHALL NOT move any pointer.
REQ-008 A tile SHALL count as complete, and tile_count_o SHALL increment, in the cycle after its last row is accepted.
REQ-009 valid_o SHALL equal (tile_count_o != 0); rows of a partial tile SHALL NOT be readable.
REQ-010 A read SHALL be accepted iff read_en_i && valid_o; read_en_i while !valid_o SHALL be ignored.
REQ-011 Read latency SHALL be one cycle: a row accepted in cycle N appears on data_o in cycle N+1.
REQ-012 data_o SHALL hold its last value when no read is accepted.
REQ-013 In the cycle the TILE_ROWS-th row of the head tile is read:
- tile_done_o SHALL pulse in cycle N+1, aligned with that row on data_o;
- tile_count_o SHALL decrement in cycle N+1.
REQ-014 A simultaneous tile completion on write and tile consumption on read SHALL leave tile_count_o unchanged.
REQ-015 Free slots SHALL equal DEPTH_TILES minus tile_count_o, minus 1 while the FSM is in REQUEST or RECEIVE; the FSM SHALL never overwrite unread rows.

Reset
REQ-016 While rst_i is high, the block SHALL asynchronously clear pointers, row counters and the FSM (to IDLE), and drive request_data_o=0, valid_o=0, tile_count_o=0, tile_done_o=0, data_o=0 and err_o=0.
REQ-017 Reset SHALL NOT clear storage contents.
REQ-018 Reset asserted mid-tile SHALL discard partial fill and read progress.
REQ-019 The first request after reset SHALL assert in the second cycle after rst_i deasserts.

Configuration
REQ-020 With WFIFO_ERR_FLAGS_EN defined, err_o SHALL exist with these sticky bits, cleared only by reset:
- err_o[0]: a dropped write (REQ-007);
- err_o[1]: read_en_i while !valid_o.
REQ-021 Without WFIFO_ERR_FLAGS_EN, the err_o port SHALL be absent and both conditions SHALL be silently ignored.

Verification
REQ-022 Using default parameters, a bench SHALL cover these directed scenarios:
- Fill: reset, then 32 rows with sending_data_i=1 -> request_data_o drops after the first row; tile_count_o=1 and valid_o=1 one cycle after row 32.
- Read latency: 32 back-to-back reads of rows 0..31 -> data_o matches each row one cycle later; tile_done_o pulses with row 31; tile_count_o returns to 0.
- Full: 2 tiles filled with no reads -> request_data_o stays 0 and tile_count_o=2; a 65th row is dropped (err_o[0]=1 with macro).
- Overlap and wrap: tile_count_o=1, then fill tile 3 while reading tile 2 with both completing in the same cycle -> tile_count_o stays 1; the write pointer wraps to 0 with no corruption.
- Underflow: read_en_i=1 with valid_o=0 -> data_o unchanged; err_o[1]=1 with macro; the port is absent without it.
- Reset mid-operation: rst_i pulsed after 10 rows of a fill -> all outputs 0; the next full tile reads back correctly.
